// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, ctrl layout and helpers shared by the machine timer.
package timer_pkg;
    localparam logic [4:0] TMR_MTIME_LO = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI = 5'h04;
    localparam logic [4:0] TMR_CMP_LO   = 5'h08;
    localparam logic [4:0] TMR_CMP_HI   = 5'h0C;
    localparam logic [4:0] TMR_CTRL     = 5'h10;

    localparam int TMR_CTRL_EN_BIT  = 0;
    localparam int TMR_CTRL_DIV_LSB = 8;

    // Mirrors the 32-bit ctrl word; div is sized for the widest legal prescaler.
    typedef struct packed {
        logic [31-TMR_CTRL_DIV_LSB:0] div;
        logic [TMR_CTRL_DIV_LSB-2:0]  rsvd;
        logic                         en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_mask(input int div_w);
        return (((32'd1 << div_w) - 32'd1) << TMR_CTRL_DIV_LSB) | (32'd1 << TMR_CTRL_EN_BIT);
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by div+1 while enabled, producing a one-cycle mtime tick.
module timer_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div,
    input  logic         clr,
    output logic         tick
);
    logic [W-1:0] cnt;

    // A ctrl write restarts the period, so the tick landing on that edge is dropped.
    assign tick = en && !clr && (cnt == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == div) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped mtime/mtimecmp with prescaler, level interrupt and rising-edge trap pulse.
module timer_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        timer_irq,
    output logic        timer_trap
);
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    ctrl_t       ctrl;
    logic [4:0]  off;
    logic        we;
    logic        tick;
    logic        irq_next;

    assign sel      = addr[31:5] == BASE_ADDR[31:5];
    assign off      = addr[4:0] & 5'b11100;
    assign we       = wr_en && sel;
    assign irq_next = mtime >= mtimecmp;

    always_comb
        rdata = !(rd_en && sel)       ? 32'd0 :
                off == TMR_MTIME_LO   ? mtime[31:0] :
                off == TMR_MTIME_HI   ? mtime[63:32] :
                off == TMR_CMP_LO     ? mtimecmp[31:0] :
                off == TMR_CMP_HI     ? mtimecmp[63:32] :
                off == TMR_CTRL       ? ctrl :
                32'd0;

    timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl.en),
        .div  (ctrl.div[PRESCALE_W-1:0]),
        .clr  (we && off == TMR_CTRL),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            ctrl       <= '0;
            timer_irq  <= 1'b0;
            timer_trap <= 1'b0;
        end else begin
            timer_irq  <= irq_next;
            timer_trap <= irq_next && !timer_irq;
            // A half write wins over the tick so software can load mtime without carry races.
            if (we && off == TMR_MTIME_LO)
                mtime[31:0] <= wdata;
            else if (we && off == TMR_MTIME_HI)
                mtime[63:32] <= wdata;
            else if (tick)
                mtime <= mtime + 64'd1;
            if (we && off == TMR_CMP_LO)
                mtimecmp[31:0] <= wdata;
            if (we && off == TMR_CMP_HI)
                mtimecmp[63:32] <= wdata;
            if (we && off == TMR_CTRL)
                ctrl <= ctrl_t'(wdata & ctrl_mask(PRESCALE_W));
        end
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed scenarios plus randomized bus traffic checked against a behavioural timer model.
module tb_timer_unit;
    import timer_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        timer_irq;
    logic        timer_trap;

    always #5 clk = ~clk;

    timer_unit #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rdata      (rdata),
        .sel        (sel),
        .timer_irq  (timer_irq),
        .timer_trap (timer_trap)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_trap = 0;

    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    int          m_div;
    int          m_phase;
    logic        m_irq;
    logic        m_trap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_time  = '0;
        m_cmp   = '1;
        m_en    = 1'b0;
        m_div   = 0;
        m_phase = 0;
        m_irq   = 1'b0;
        m_trap  = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
        if (!r || a[31:5] != BASE[31:5])
            return 32'd0;
        case (a[4:2])
            3'd0: return m_time[31:0];
            3'd1: return m_time[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {16'd0, 8'(m_div), 7'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    // mtime advances on every (div+1)-th enabled cycle counted from the last ctrl write.
    task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic       hit;
        logic [2:0] o;
        logic       tick;
        hit  = w && a[31:5] == BASE[31:5];
        o    = a[4:2];
        tick = 1'b0;
        m_trap = (m_time >= m_cmp) && !m_irq;
        m_irq  = m_time >= m_cmp;
        if (hit && o == 3'd4) begin
            m_en    = d[0];
            m_div   = int'(d[15:8]);
            m_phase = 0;
        end else if (m_en) begin
            tick = (m_phase % (m_div + 1)) == m_div;
            m_phase++;
        end
        if (hit && o == 3'd0)
            m_time[31:0] = d;
        else if (hit && o == 3'd1)
            m_time[63:32] = d;
        else if (tick)
            m_time = m_time + 64'd1;
        if (hit && o == 3'd2) m_cmp[31:0] = d;
        if (hit && o == 3'd3) m_cmp[63:32] = d;
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        #1;
        check("rdata", rdata, m_read(r, a));
        check("sel", sel, a[31:5] == BASE[31:5]);
        @(posedge clk);
        m_step(w, a, d);
        #1;
        check("irq", timer_irq, m_irq);
        check("trap", timer_trap, m_trap);
        if (timer_trap) n_trap++;
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        bus(1'b1, 1'b0, BASE + 32'(o), d);
    endtask

    task automatic idle();
        bus(1'b0, 1'b1, BASE + 32'($urandom_range(0, 7) * 4), 32'd0);
    endtask

    task automatic peek(input string tag, input logic [4:0] o, input logic [31:0] exp);
        wr_en = 1'b0;
        rd_en = 1'b1;
        addr  = BASE + 32'(o);
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        m_reset();
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_irq", timer_irq, 1'b0);
        check("rst_trap", timer_trap, 1'b0);

        repeat (100) idle();
        check("t1_no_trap", n_trap, 0);
        peek("t1_mtime_lo", TMR_MTIME_LO, 32'd0);
        peek("t1_cmp_lo", TMR_CMP_LO, 32'hFFFF_FFFF);
        peek("t1_cmp_hi", TMR_CMP_HI, 32'hFFFF_FFFF);

        wr(TMR_CMP_HI, 32'd0);
        wr(TMR_CMP_LO, 32'd10);
        n_trap = 0;
        wr(TMR_CTRL, 32'h1);
        repeat (10) idle();
        peek("t2_mtime10", TMR_MTIME_LO, 32'd10);
        check("t2_irq_not_yet", timer_irq, 1'b0);
        idle();
        check("t2_irq_rise", timer_irq, 1'b1);
        check("t2_trap", timer_trap, 1'b1);
        repeat (5) idle();
        check("t2_one_trap", n_trap, 1);
        check("t2_irq_held", timer_irq, 1'b1);

        wr(TMR_CTRL, 32'h0);
        wr(TMR_MTIME_LO, 32'd0);
        wr(TMR_MTIME_HI, 32'd0);
        wr(TMR_CTRL, 32'h0301);
        repeat (40) idle();
        peek("t3_mtime_div3", TMR_MTIME_LO, 32'd10);
        peek("t3_ctrl", TMR_CTRL, 32'h0301);

        wr(TMR_CTRL, 32'h0);
        wr(TMR_MTIME_LO, 32'hFFFF_FFFF);
        wr(TMR_MTIME_HI, 32'd0);
        wr(TMR_CTRL, 32'h1);
        idle();
        peek("t4_carry_lo", TMR_MTIME_LO, 32'd0);
        peek("t4_carry_hi", TMR_MTIME_HI, 32'd1);
        wr(TMR_MTIME_HI, 32'd5);
        peek("t4_hi_write", TMR_MTIME_HI, 32'd5);
        peek("t4_lo_kept", TMR_MTIME_LO, 32'd0);

        wr(TMR_MTIME_HI, 32'd0);
        repeat (12) idle();
        check("t5_irq_high", timer_irq, 1'b1);
        n_trap = 0;
        wr(TMR_CMP_LO, m_time[31:0] + 32'd100);
        idle();
        check("t5_irq_cleared", timer_irq, 1'b0);
        repeat (110) idle();
        check("t5_one_trap", n_trap, 1);
        check("t5_irq_again", timer_irq, 1'b1);

        #2 rst = 1'b0;
        #1;
        m_reset();
        check("t6_irq_async", timer_irq, 1'b0);
        check("t6_trap_async", timer_trap, 1'b0);
        peek("t6_mtime_async", TMR_MTIME_LO, 32'd0);
        peek("t6_cmp_async", TMR_CMP_LO, 32'hFFFF_FFFF);
        peek("t6_ctrl_async", TMR_CTRL, 32'd0);
        #1 rst = 1'b1;
        wr(5'h1C, 32'hDEAD_BEEF);
        peek("t6_rsvd18", 5'h18, 32'd0);
        peek("t6_rsvd1c", 5'h1C, 32'd0);
        bus(1'b1, 1'b0, 32'h0000_0000, 32'd77);
        bus(1'b0, 1'b1, 32'h4000_0000, 32'd0);
        peek("t6_outside_ignored", TMR_MTIME_LO, 32'd0);

        repeat (400) begin
            case ($urandom_range(0, 9))
                0: begin
                    d = $urandom;
                    d[15:10] = '0;
                    wr(TMR_CTRL, d);
                end
                1: wr(TMR_MTIME_LO, 32'($urandom_range(0, 60)));
                2: wr(TMR_MTIME_HI, 32'($urandom_range(0, 1)));
                3: wr(TMR_CMP_LO, 32'($urandom_range(0, 80)));
                4: wr(TMR_CMP_HI, 32'($urandom_range(0, 1)));
                5: bus(1'b1, 1'b1, BASE + 32'($urandom_range(0, 4) * 4), 32'($urandom_range(0, 70)));
                6: bus(1'b0, 1'b1, $urandom, 32'd0);
                default: idle();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
